fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter sharing one FIFO write port among NUM_REQ requesters.
- Each requester uses a valid/ready handshake. The arbiter drives the FIFO's we/data_in and honours fifo_full.
- Bursts are capped per grant so no requester can monopolise the FIFO.
- Sits directly in front of the FIFO; the read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ valid/ready requesters.
// Each grant is capped at BURST_MAX beats, and every release is followed by one idle cycle.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no grant held; picks the next requester after last_grant
//   ST_GRANT | grant_id owns the write port; words pass straight to the FIFO
module fifo_wr_arbiter #(
    parameter int width     = 16,
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 4,
    parameter int ID_W      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*width-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_we,
    output logic [width-1:0]         fifo_data_in,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy
);

    localparam int CNT_W = $clog2(BURST_MAX) + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   last_grant;
    logic [CNT_W-1:0]  beat_cnt;
    logic              arb_found;
    logic [ID_W-1:0]   arb_idx;
    logic              g_valid;
    logic              beat;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!arb_found && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
                arb_found = 1'b1;
                arb_idx   = ID_W'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        req_ready    = '0;
        fifo_we      = 1'b0;
        fifo_data_in = '0;
        g_valid      = 1'b0;
        beat         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_found) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                g_valid = req_valid[grant_id];
                if (g_valid && !fifo_full) begin
                    req_ready[grant_id] = 1'b1;
                    fifo_we             = 1'b1;
                    fifo_data_in        = req_data[int'(grant_id)*width +: width];
                    beat                = 1'b1;
                end
                // A full FIFO only stalls; a dropped valid releases even while full.
                if (!g_valid) begin
                    state_nxt = ST_IDLE;
                end else if (beat && beat_cnt == CNT_W'(BURST_MAX - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && arb_found) begin
                grant_id   <= arb_idx;
                last_grant <= arb_idx;
                beat_cnt   <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    assign busy = (state == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester word queues feed the DUT, and the writes
// the FIFO would see are logged and compared against hand-computed expectations.
module tb_fifo_wr_arbiter;

    localparam int W = 16;
    localparam int N = 4;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             fifo_full;
    logic             fifo_we;
    logic [W-1:0]     fifo_data_in;
    logic [1:0]       grant_id;
    logic             busy;

    fifo_wr_arbiter #(.width(W), .NUM_REQ(N), .BURST_MAX(4), .ID_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_we      (fifo_we),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] src_q [N][$];
    logic [W-1:0] wr_q [$];
    int           wr_gid [$];
    int           vec_cnt = 0;
    int           err_cnt = 0;
    int           onehot_viol = 0;
    int           full_viol = 0;
    bit           full_force = 1'b0;
    bit           full_toggle = 1'b0;
    logic         s_we, s_busy;
    logic [N-1:0] s_ready;
    logic [1:0]   s_gid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pending();
        int t = 0;
        for (int i = 0; i < N; i++) t += src_q[i].size();
        return t;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (src_q[i].size() > 0);
            req_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
        if (full_toggle) fifo_full = ~fifo_full;
        else             fifo_full = full_force;
    endtask

    // Sample at the falling edge, then apply the next inputs just after the rising edge.
    task automatic run_cycle();
        @(negedge clk);
        s_we    = fifo_we;
        s_busy  = busy;
        s_ready = req_ready;
        s_gid   = grant_id;
        if (fifo_we) begin
            wr_q.push_back(fifo_data_in);
            wr_gid.push_back(int'(grant_id));
        end
        if (fifo_we && fifo_full) full_viol++;
        if ($countones(req_ready) > 1) onehot_viol++;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    task automatic clear_logs();
        wr_q.delete();
        wr_gid.delete();
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 200 && pending() > 0; c++) run_cycle();
        check(tag, pending(), 0);
        repeat (2) run_cycle();
    endtask

    initial begin
        logic [8:0] we_tr9;
        logic [4:0] we_tr5;
        logic [4:0] busy_tr5;
        int         seg_id [$];
        int         seg_len [$];
        int         exp_ids [5];

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", fifo_we, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_gid", grant_id, 0);

        // Single requester, 6 words: burst of 4, bubble, then 2.
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) src_q[0].push_back(W'(k));
        drive();
        for (int c = 0; c < 9; c++) begin
            run_cycle();
            we_tr9[c] = s_we;
        end
        check("t1_we_trace", we_tr9, 9'b011011110);
        check("t1_count", wr_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t1_data%0d", k), wr_q[k], k + 1);
            check($sformatf("t1_gid%0d", k), wr_gid[k], 0);
        end
        repeat (2) run_cycle();

        // All requesters continuously valid, 8 words each.
        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 8; j++) src_q[i].push_back(W'(i*256 + j));
        drive();
        drain("t2_drain");
        check("t2_total", wr_q.size(), 32);
        foreach (wr_gid[k]) begin
            if (k == 0 || wr_gid[k] != wr_gid[k-1]) begin
                seg_id.push_back(wr_gid[k]);
                seg_len.push_back(1);
            end else begin
                seg_len[seg_len.size()-1] = seg_len[seg_len.size()-1] + 1;
            end
        end
        exp_ids = '{0, 1, 2, 3, 0};
        for (int s = 0; s < 5; s++) begin
            check($sformatf("t2_seg%0d_id", s), seg_id[s], exp_ids[s]);
            check($sformatf("t2_seg%0d_len", s), seg_len[s], 4);
        end
        check("t2_r0_second_burst", wr_q[16], 16'h0004);
        check("t2_onehot", onehot_viol, 0);

        // Requester 2 stalled by fifo_full after 2 beats.
        clear_logs();
        for (int j = 0; j < 4; j++) src_q[2].push_back(W'(16'h2A00 + j));
        drive();
        repeat (3) run_cycle();
        full_force = 1'b1;
        drive();
        for (int s = 0; s < 5; s++) begin
            if (s == 4) full_force = 1'b0;
            run_cycle();
            check($sformatf("t3_stall_we%0d", s), s_we, 0);
            check($sformatf("t3_stall_ready%0d", s), s_ready, 0);
            check($sformatf("t3_stall_gid%0d", s), s_gid, 2);
            check($sformatf("t3_beat_cnt%0d", s), dut.beat_cnt, 2);
        end
        run_cycle();
        check("t3_beat3_we", s_we, 1);
        run_cycle();
        check("t3_beat4_we", s_we, 1);
        run_cycle();
        check("t3_released", s_busy, 0);
        check("t3_count", wr_q.size(), 4);
        for (int k = 0; k < 4; k++) check($sformatf("t3_data%0d", k), wr_q[k], 16'h2A00 + k);

        // Requester 1 drops valid after one beat, requester 3 follows after the bubble.
        do_reset();
        clear_logs();
        src_q[1].push_back(16'h1100);
        for (int j = 0; j < 4; j++) src_q[3].push_back(W'(16'h3300 + j));
        drive();
        for (int c = 0; c < 5; c++) begin
            run_cycle();
            we_tr5[c]   = s_we;
            busy_tr5[c] = s_busy;
        end
        check("t4_we_trace", we_tr5, 5'b10010);
        check("t4_busy_trace", busy_tr5, 5'b10110);
        check("t4_first_gid", wr_gid[0], 1);
        check("t4_next_gid", s_gid, 3);

        // Reset in the middle of requester 3's burst, after its second beat.
        run_cycle();
        #2;
        check("t5_pre_rst_we", fifo_we, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_we", fifo_we, 0);
        check("t5_rst_ready", req_ready, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_gid", grant_id, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 4; j++) src_q[i].push_back(W'(i*256 + j));
        drive();
        run_cycle();
        run_cycle();
        check("t5_first_gid", s_gid, 0);
        check("t5_first_we", s_we, 1);
        drain("t5_drain");

        // fifo_full toggling every cycle with extreme data values.
        clear_logs();
        src_q[0].push_back(16'hFFFF);
        src_q[0].push_back(16'h0000);
        full_toggle = 1'b1;
        drive();
        for (int c = 0; c < 20 && pending() > 0; c++) run_cycle();
        full_toggle = 1'b0;
        full_force  = 1'b0;
        drive();
        repeat (2) run_cycle();
        check("t6_count", wr_q.size(), 2);
        check("t6_word0", wr_q[0], 16'hFFFF);
        check("t6_word1", wr_q[1], 16'h0000);
        check("t6_we_while_full", full_viol, 0);
        check("onehot_total", onehot_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
